edge_detect_mc: RTL and testbench

- Multi-channel, parametrised successor to the single-bit synchroniser plus rising-edge pulser.
- Each channel: N-flop synchroniser, glitch filter, run-time edge-mode select (rise/fall/both/off), single-cycle event pulse, and a sticky event flag with clear.
- Sits at the clkb-domain boundary for asynchronous level inputs: IRQ lines, status pins, slow handshake wires.

---
 rtl/edge_pkg.sv | 37 +++
 rtl/edge_detect_mc_chan.sv | 106 ++++++++++
 rtl/edge_detect_mc.sv | 66 ++++++
 tb/tb_edge_detect_mc.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// ============================================================================
//  edge_pkg : shared types, mode encodings and parameter limits for edge_detect_mc
//  Revision : 1.0
// ============================================================================
`default_nettype none

package edge_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t MODE_OFF  = 2'b00;
    localparam edge_mode_t MODE_RISE = 2'b01;
    localparam edge_mode_t MODE_FALL = 2'b10;
    localparam edge_mode_t MODE_BOTH = 2'b11;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILT_CYC_MIN    = 1;
    localparam int FILT_CYC_MAX    = 255;

    // Selects which of the detected transitions are reported for a given mode.
    function automatic logic mode_hit(edge_mode_t m, logic rise, logic fall);
        logic hit;
        hit = 1'b0;
        case (m)
            MODE_OFF:  hit = 1'b0;
            MODE_RISE: hit = rise;
            MODE_FALL: hit = fall;
            MODE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/edge_detect_mc_chan.sv
// ============================================================================
//  edge_chan : one channel - synchroniser, glitch filter, edge detect, sticky
//              flag and (with EDGE_CNT_EN) a saturating event counter
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 1
`ifdef EDGE_CNT_EN
    ,
    parameter int CNT_W       = 8
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_i,
    input  edge_mode_t       mode_i,
    input  logic             clr_i,
    output logic             pulse_o,
    output logic             level_o,
    output logic             flag_o
`ifdef EDGE_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_o
`endif
);

    localparam int              FC_W    = $clog2(FILT_CYC + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYC - 1);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [FC_W-1:0]        fc_q, fc_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   flag_q, flag_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        fc_d    = fc_q;
        level_d = level_q;
        if (sync_s == level_q) begin
            fc_d = '0;
        end else if (fc_q == FC_LAST) begin
            level_d = sync_s;
            fc_d    = '0;
        end else begin
            fc_d = fc_q + FC_ONE;
        end
        // Compare next-state level against current so the pulse lines up with level.
        pulse_d = mode_hit(mode_i, level_d & ~level_q, ~level_d & level_q);
        flag_d  = pulse_q | (flag_q & ~clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            fc_q    <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], data_i};
            fc_q    <= fc_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
        end
    end

    assign pulse_o = pulse_q;
    assign level_o = level_q;
    assign flag_o  = flag_q;

`ifdef EDGE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CNT_W'(pulse_q);
        end else if (pulse_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`endif

endmodule

`default_nettype wire

// File: rtl/edge_detect_mc.sv
// ============================================================================
//  edge_detect_mc : multi-channel synchronising edge detector with sticky flags
//                   Optional macro EDGE_CNT_EN adds per-channel event counters.
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module edge_detect_mc
    import edge_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 1,
    parameter int CNT_W       = 8
) (
    input  logic              clkb,
    input  logic              rstb,
    input  logic [CH-1:0]     dataa,
    input  logic [2*CH-1:0]   mode,
    input  logic [CH-1:0]     clr,
    output logic [CH-1:0]     doutb,
    output logic [CH-1:0]     level,
    output logic [CH-1:0]     flag
`ifdef EDGE_CNT_EN
    ,
    output logic [CH*CNT_W-1:0] evcnt
`endif
);

    if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_sync
        $error("edge_detect_mc: SYNC_STAGES out of range");
    end
    if ((FILT_CYC < FILT_CYC_MIN) || (FILT_CYC > FILT_CYC_MAX)) begin : g_bad_filt
        $error("edge_detect_mc: FILT_CYC out of range");
    end
    if ((CH < 1) || (CNT_W < 1)) begin : g_bad_width
        $error("edge_detect_mc: CH and CNT_W must be at least 1");
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYC    (FILT_CYC)
`ifdef EDGE_CNT_EN
            ,
            .CNT_W       (CNT_W)
`endif
        ) u_chan (
            .clk_i   (clkb),
            .rst_i   (rstb),
            .data_i  (dataa[i]),
            .mode_i  (edge_mode_t'(mode[2*i +: 2])),
            .clr_i   (clr[i]),
            .pulse_o (doutb[i]),
            .level_o (level[i]),
            .flag_o  (flag[i])
`ifdef EDGE_CNT_EN
            ,
            .cnt_o   (evcnt[i*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_edge_detect_mc.sv
// ============================================================================
//  tb_edge_detect_mc : directed self-checking bench for edge_detect_mc
//  Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_edge_detect_mc;

    logic       clkb;
    logic       rstb;
    logic [3:0] dataa;
    logic [7:0] mode;
    logic [3:0] clr;
    logic [3:0] doutb,   level,   flag;
    logic [3:0] doutb_f, level_f, flag_f;
`ifdef EDGE_CNT_EN
    logic [7:0]  evcnt;
    logic [31:0] evcnt_f;
`endif

    int checks = 0;
    int errors = 0;

    edge_detect_mc #(.CH(4), .SYNC_STAGES(2), .FILT_CYC(1), .CNT_W(2)) dut (
        .clkb  (clkb),
        .rstb  (rstb),
        .dataa (dataa),
        .mode  (mode),
        .clr   (clr),
        .doutb (doutb),
        .level (level),
        .flag  (flag)
`ifdef EDGE_CNT_EN
        ,
        .evcnt (evcnt)
`endif
    );

    edge_detect_mc #(.CH(4), .SYNC_STAGES(2), .FILT_CYC(3), .CNT_W(8)) dut_f (
        .clkb  (clkb),
        .rstb  (rstb),
        .dataa (dataa),
        .mode  (mode),
        .clr   (clr),
        .doutb (doutb_f),
        .level (level_f),
        .flag  (flag_f)
`ifdef EDGE_CNT_EN
        ,
        .evcnt (evcnt_f)
`endif
    );

    initial clkb = 1'b0;
    always #5 clkb = ~clkb;

    task automatic tick();
        @(posedge clkb);
        #1;
    endtask

    task automatic test_reset();
        rstb = 1'b1; dataa = '0; mode = '0; clr = '0;
        tick(); tick();
        checks++;
        if ({doutb, level, flag} !== 12'h000) begin
            errors++;
            $display("FAIL reset_dut: got %b/%b/%b want 0", doutb, level, flag);
        end
        checks++;
        if ({doutb_f, level_f, flag_f} !== 12'h000) begin
            errors++;
            $display("FAIL reset_dut_f: got %b/%b/%b want 0", doutb_f, level_f, flag_f);
        end
        rstb = 1'b0;
        tick();
        checks++;
        if ({doutb, level, flag} !== 12'h000) begin
            errors++;
            $display("FAIL post_reset_idle: got %b/%b/%b want 0", doutb, level, flag);
        end
    endtask

    task automatic test_basic_rise();
        int n;
        mode = 8'b01_01_11_01;
        dataa[0] = 1'b1;
        tick(); tick();
        checks++;
        if (doutb[0] !== 1'b0 || level[0] !== 1'b0) begin
            errors++;
            $display("FAIL rise_early: got doutb=%b level=%b want 0 0", doutb[0], level[0]);
        end
        tick();
        checks++;
        if (doutb[0] !== 1'b1 || level[0] !== 1'b1 || flag[0] !== 1'b0) begin
            errors++;
            $display("FAIL rise_edge3: got doutb=%b level=%b flag=%b want 1 1 0", doutb[0], level[0], flag[0]);
        end
        tick();
        checks++;
        if (doutb[0] !== 1'b0 || flag[0] !== 1'b1) begin
            errors++;
            $display("FAIL rise_edge4: got doutb=%b flag=%b want 0 1", doutb[0], flag[0]);
        end
        dataa[0] = 1'b0;
        n = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (doutb[0]) n++;
        end
        checks++;
        if (n != 0 || level[0] !== 1'b0) begin
            errors++;
            $display("FAIL rise_no_fall_pulse: got pulses=%0d level=%b want 0 0", n, level[0]);
        end
    endtask

    task automatic test_both_edges();
        int n, p0, p1;
        for (int pass = 0; pass < 2; pass++) begin
            mode[3:2] = (pass == 0) ? 2'b11 : 2'b10;
            dataa[1] = 1'b1;
            n = 0; p0 = -1; p1 = -1;
            for (int t = 1; t <= 25; t++) begin
                tick();
                if (doutb[1]) begin
                    if (n == 0) p0 = t; else p1 = t;
                    n++;
                end
                if (t == 10) dataa[1] = 1'b0;
            end
            checks++;
            if (pass == 0 && (n != 2 || p0 != 3 || p1 != 13)) begin
                errors++;
                $display("FAIL both_mode: got n=%0d at %0d,%0d want 2 at 3,13", n, p0, p1);
            end else if (pass == 1 && (n != 1 || p0 != 13)) begin
                errors++;
                $display("FAIL fall_mode: got n=%0d at %0d want 1 at 13", n, p0);
            end
        end
        n = 0;
        mode[3:2] = 2'b00; tick(); if (doutb[1]) n++;
        mode[3:2] = 2'b11; tick(); if (doutb[1]) n++;
        mode[3:2] = 2'b01; tick(); if (doutb[1]) n++;
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL mode_change_pulse: got pulses=%0d want 0", n);
        end
    endtask

    task automatic run_glitch(input logic [15:0] pat, output int n, output int first, output logic lvl5);
        n = 0; first = -1; lvl5 = 1'b0;
        for (int t = 0; t < 16; t++) begin
            dataa[2] = pat[t];
            tick();
            if (doutb_f[2]) begin
                if (n == 0) first = t + 1;
                n++;
            end
            if (t == 4) lvl5 = level_f[2];
        end
        dataa[2] = 1'b0;
    endtask

    task automatic test_glitch_filter();
        int   n, first;
        logic lvl5;
        run_glitch(16'b0000_0000_0000_0011, n, first, lvl5);
        checks++;
        if (n != 0 || lvl5 !== 1'b0) begin
            errors++;
            $display("FAIL glitch_2cyc: got pulses=%0d level=%b want 0 0", n, lvl5);
        end
        run_glitch(16'b0000_0000_0001_1011, n, first, lvl5);
        checks++;
        if (n != 0 || lvl5 !== 1'b0) begin
            errors++;
            $display("FAIL glitch_fc_restart: got pulses=%0d level=%b want 0 0", n, lvl5);
        end
        run_glitch(16'b0000_0000_0000_0111, n, first, lvl5);
        checks++;
        if (n != 1 || first != 5 || lvl5 !== 1'b1) begin
            errors++;
            $display("FAIL glitch_3cyc: got pulses=%0d at %0d level=%b want 1 at 5 level 1", n, first, lvl5);
        end
        checks++;
        if (level_f[2] !== 1'b0 || flag_f[2] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_settle: got level=%b flag=%b want 0 1", level_f[2], flag_f[2]);
        end
    endtask

    task automatic test_flag_race();
        dataa[3] = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (doutb[3] !== 1'b1 || flag[3] !== 1'b0) begin
            errors++;
            $display("FAIL race_pulse: got doutb=%b flag=%b want 1 0", doutb[3], flag[3]);
        end
        clr[3] = 1'b1;
        tick();
        checks++;
        if (flag[3] !== 1'b1) begin
            errors++;
            $display("FAIL race_set_wins: got flag=%b want 1", flag[3]);
        end
        tick();
        checks++;
        if (flag[3] !== 1'b0 || flag[0] !== 1'b1) begin
            errors++;
            $display("FAIL race_clear: got flag3=%b flag0=%b want 0 1", flag[3], flag[0]);
        end
        clr[3] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n0, n3, nf;
        dataa[0] = 1'b1;
        dataa[2] = 1'b1;
        tick(); tick(); tick();
        rstb = 1'b1;
        tick();
        checks++;
        if ({doutb, level, flag, doutb_f, level_f, flag_f} !== 24'h0) begin
            errors++;
            $display("FAIL reset_mid: got %b %b %b / %b %b %b want all 0",
                     doutb, level, flag, doutb_f, level_f, flag_f);
        end
        rstb = 1'b0;
        n0 = 0; n3 = 0; nf = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (doutb[0])   n0++;
            if (doutb[3])   n3++;
            if (doutb_f[2]) nf++;
        end
        checks++;
        if (n0 != 1 || n3 != 1 || nf != 1) begin
            errors++;
            $display("FAIL reset_release_pulse: got %0d %0d %0d want 1 1 1", n0, n3, nf);
        end
    endtask

`ifdef EDGE_CNT_EN
    task automatic test_counter();
        int exp;
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        tick();
        checks++;
        if (evcnt[1:0] !== 2'd0 || flag[0] !== 1'b0) begin
            errors++;
            $display("FAIL cnt_clear: got evcnt=%0d flag=%b want 0 0", evcnt[1:0], flag[0]);
        end
        for (int k = 1; k <= 5; k++) begin
            dataa[0] = 1'b0;
            tick(); tick(); tick();
            dataa[0] = 1'b1;
            tick(); tick(); tick(); tick();
            exp = (k > 3) ? 3 : k;
            checks++;
            if (evcnt[1:0] !== 2'(exp)) begin
                errors++;
                $display("FAIL cnt_event%0d: got %0d want %0d", k, evcnt[1:0], exp);
            end
        end
        dataa[0] = 1'b0;
        tick(); tick(); tick();
        dataa[0] = 1'b1;
        tick(); tick(); tick();
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        checks++;
        if (evcnt[1:0] !== 2'd1 || flag[0] !== 1'b1) begin
            errors++;
            $display("FAIL cnt_clr_race: got evcnt=%0d flag=%b want 1 1", evcnt[1:0], flag[0]);
        end
    endtask
`endif

    initial begin
        rstb = 1'b1; dataa = '0; mode = '0; clr = '0;
        test_reset();
        test_basic_rise();
        test_both_edges();
        test_glitch_filter();
        test_flag_race();
        test_reset_mid();
`ifdef EDGE_CNT_EN
        test_counter();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
